// File: rtl/rst_sequencer_if.sv
// Sequencer-side signal bundle: asynchronous lock flags in, staged reset
// requests and status out. Clock and reset stay as plain module ports.
interface rst_sequencer_if #(
    parameter int N_LOCKS     = 2,
    parameter int N_DOMAINS   = 4,
    parameter int MAX_RETRIES = 3
);
    localparam int RCW = $clog2(MAX_RETRIES + 1);

    logic [N_LOCKS-1:0]   lockedIn;
    logic                 mmcmRstOut;
    logic [N_DOMAINS-1:0] rstReqOut;
    logic                 readyOut;
    logic                 errorOut;
    logic [RCW-1:0]       retryCntOut;
    logic [7:0]           lossCntOut;
    logic [2:0]           stateOut;

    modport master (
        input  lockedIn,
        output mmcmRstOut, rstReqOut, readyOut, errorOut,
        output retryCntOut, lossCntOut, stateOut
    );

    modport slave (
        output lockedIn,
        input  mmcmRstOut, rstReqOut, readyOut, errorOut,
        input  retryCntOut, lossCntOut, stateOut
    );
endinterface

// File: rtl/rst_sequencer.sv
// Reset/lock sequencer: pulses the MMCM reset, filters lock with timeout and
// retry, then releases domain reset requests one at a time.
module rst_sequencer #(
    parameter int N_LOCKS         = 2,
    parameter int N_DOMAINS       = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int MMCM_RST_CYCLES = 16,
    parameter int LOCK_FILTER     = 4,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int STAGE_DELAY     = 8,
    parameter int MAX_RETRIES     = 3
) (
    input  logic             clkIn,
    input  logic             rstIn,
    rst_sequencer_if.master  bus
);
    localparam int RCW = $clog2(MAX_RETRIES + 1);
    localparam int MW  = $clog2(MMCM_RST_CYCLES + 1);
    localparam int FW  = $clog2(LOCK_FILTER + 1);
    localparam int TW  = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW  = $clog2(STAGE_DELAY + 1);

    localparam logic [MW-1:0]  MMCM_END   = MW'(MMCM_RST_CYCLES);
    localparam logic [FW-1:0]  FILT_LAST  = FW'(LOCK_FILTER - 1);
    localparam logic [TW-1:0]  TMO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0]  STAGE_LAST = SW'(STAGE_DELAY - 1);
    localparam logic [RCW-1:0] RETRY_MAX  = RCW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RST_MMCM  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc8 = v;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    logic [N_LOCKS-1:0]   sync_q [SYNC_STAGES];
    logic                 lock_ok_s;

    state_e               state_q,     state_d;
    logic [MW-1:0]        mmcm_cnt_q,  mmcm_cnt_d;
    logic [FW-1:0]        filt_cnt_q,  filt_cnt_d;
    logic [TW-1:0]        tmo_cnt_q,   tmo_cnt_d;
    logic [SW-1:0]        stage_cnt_q, stage_cnt_d;
    logic                 mmcm_rst_q,  mmcm_rst_d;
    logic [N_DOMAINS-1:0] rst_req_q,   rst_req_d;
    logic                 ready_q,     ready_d;
    logic                 error_q,     error_d;
    logic [RCW-1:0]       retry_q,     retry_d;
    logic [7:0]           loss_q,      loss_d;

    // Lock flag synchroniser chain, cleared by reset.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.lockedIn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign lock_ok_s = &sync_q[SYNC_STAGES-1];

    // Next-state and output logic. Re-entries into RST_MMCM from timeout or
    // lock loss preload the pulse counter with 1: the transition edge has
    // already sampled rstIn low, so the pulse is MMCM_RST_CYCLES wide there too.
    always_comb begin
        state_d     = state_q;
        mmcm_cnt_d  = mmcm_cnt_q;
        filt_cnt_d  = filt_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        stage_cnt_d = stage_cnt_q;
        mmcm_rst_d  = mmcm_rst_q;
        rst_req_d   = rst_req_q;
        ready_d     = ready_q;
        error_d     = error_q;
        retry_d     = retry_q;
        loss_d      = loss_q;

        case (state_q)
            ST_RST_MMCM: begin
                mmcm_rst_d = 1'b1;
                rst_req_d  = '1;
                ready_d    = 1'b0;
                if (mmcm_cnt_q == MMCM_END) begin
                    state_d    = ST_WAIT_LOCK;
                    mmcm_rst_d = 1'b0;
                    mmcm_cnt_d = '0;
                    filt_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end else begin
                    mmcm_cnt_d = mmcm_cnt_q + MW'(1);
                end
            end

            ST_WAIT_LOCK: begin
                mmcm_rst_d = 1'b0;
                if (lock_ok_s && (filt_cnt_q == FILT_LAST)) begin
                    state_d     = ST_RELEASE;
                    stage_cnt_d = '0;
                    filt_cnt_d  = '0;
                    tmo_cnt_d   = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    filt_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    if (retry_q < RETRY_MAX) begin
                        state_d    = ST_RST_MMCM;
                        retry_d    = retry_q + RCW'(1);
                        mmcm_rst_d = 1'b1;
                        mmcm_cnt_d = MW'(1);
                    end else begin
                        state_d = ST_FAULT;
                        error_d = 1'b1;
                    end
                end else begin
                    tmo_cnt_d  = tmo_cnt_q + TW'(1);
                    filt_cnt_d = lock_ok_s ? (filt_cnt_q + FW'(1)) : '0;
                end
            end

            ST_RELEASE: begin
                if (!lock_ok_s) begin
                    state_d     = ST_RST_MMCM;
                    mmcm_rst_d  = 1'b1;
                    mmcm_cnt_d  = MW'(1);
                    rst_req_d   = '1;
                    ready_d     = 1'b0;
                    stage_cnt_d = '0;
                    loss_d      = sat_inc8(loss_q);
                end else if (stage_cnt_q == STAGE_LAST) begin
                    stage_cnt_d = '0;
                    if (rst_req_q == '0) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                        retry_d = '0;
                    end else begin
                        // Zero shifts in at bit 0, so domains release in ascending order.
                        rst_req_d = rst_req_q << 1'b1;
                    end
                end else begin
                    stage_cnt_d = stage_cnt_q + SW'(1);
                end
            end

            ST_RUN: begin
                if (!lock_ok_s) begin
                    state_d    = ST_RST_MMCM;
                    mmcm_rst_d = 1'b1;
                    mmcm_cnt_d = MW'(1);
                    rst_req_d  = '1;
                    ready_d    = 1'b0;
                    loss_d     = sat_inc8(loss_q);
                end else begin
                    ready_d   = 1'b1;
                    rst_req_d = '0;
                end
            end

            ST_FAULT: begin
                error_d    = 1'b1;
                mmcm_rst_d = 1'b0;
                rst_req_d  = '1;
                ready_d    = 1'b0;
            end

            default: begin
                state_d    = ST_RST_MMCM;
                mmcm_rst_d = 1'b1;
                mmcm_cnt_d = '0;
                rst_req_d  = '1;
                ready_d    = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q     <= ST_RST_MMCM;
            mmcm_cnt_q  <= '0;
            filt_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            stage_cnt_q <= '0;
            mmcm_rst_q  <= 1'b1;
            rst_req_q   <= '1;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            retry_q     <= '0;
            loss_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            mmcm_cnt_q  <= mmcm_cnt_d;
            filt_cnt_q  <= filt_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            mmcm_rst_q  <= mmcm_rst_d;
            rst_req_q   <= rst_req_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
        end
    end

    assign bus.mmcmRstOut  = mmcm_rst_q;
    assign bus.rstReqOut   = rst_req_q;
    assign bus.readyOut    = ready_q;
    assign bus.errorOut    = error_q;
    assign bus.retryCntOut = retry_q;
    assign bus.lossCntOut  = loss_q;
    assign bus.stateOut    = state_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: stimulus queues edge-tagged expected
// output snapshots; a negedge monitor pops and compares them.
module tb_rst_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_n = 0;
    int   checks = 0;
    int   failures = 0;
    logic finish_req = 1'b0;

    int          exp_cyc[$];
    logic [19:0] exp_val[$];
    string       exp_name[$];
    logic [19:0] snap;

    rst_sequencer_if #(.N_LOCKS(2), .N_DOMAINS(4), .MAX_RETRIES(3)) bus ();

    rst_sequencer #(.LOCK_TIMEOUT(64)) dut (
        .clkIn (clk),
        .rstIn (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: pop every expectation due at this edge and compare the snapshot.
    always @(negedge clk) begin
        snap = {bus.stateOut, bus.mmcmRstOut, bus.rstReqOut, bus.readyOut,
                bus.errorOut, bus.retryCntOut, bus.lossCntOut};
        while (exp_cyc.size() > 0 && (exp_cyc[0] <= edge_n || finish_req)) begin
            checks = checks + 1;
            if (exp_cyc[0] != edge_n || snap !== exp_val[0]) begin
                failures = failures + 1;
                $display("FAIL %s edge=%0d due=%0d {st,mmcm,req,rdy,err,retry,loss} got=%05h expected=%05h",
                         exp_name[0], edge_n, exp_cyc[0], snap, exp_val[0]);
            end
            void'(exp_cyc.pop_front());
            void'(exp_val.pop_front());
            void'(exp_name.pop_front());
        end
    end

    task automatic expect_at(input int c, input string n, input logic [2:0] st,
                             input logic m, input logic [3:0] rq, input logic rd,
                             input logic er, input logic [1:0] rt, input logic [7:0] ls);
        exp_cyc.push_back(c);
        exp_val.push_back({st, m, rq, rd, er, rt, ls});
        exp_name.push_back(n);
    endtask

    // Direct comparison of the current outputs against an expected snapshot.
    task automatic check_now(input string n, input logic [2:0] st,
                             input logic m, input logic [3:0] rq, input logic rd,
                             input logic er, input logic [1:0] rt, input logic [7:0] ls);
        logic [19:0] got;
        logic [19:0] expv;
        got  = {bus.stateOut, bus.mmcmRstOut, bus.rstReqOut, bus.readyOut,
                bus.errorOut, bus.retryCntOut, bus.lossCntOut};
        expv = {st, m, rq, rd, er, rt, ls};
        checks = checks + 1;
        if (got !== expv) begin
            failures = failures + 1;
            $display("FAIL %s edge=%0d {st,mmcm,req,rdy,err,retry,loss} got=%05h expected=%05h",
                     n, edge_n, got, expv);
        end
    endtask

    task automatic wait_until(input int c);
        while (edge_n < c) @(negedge clk);
    endtask

    // Reset for three edges; b is the first edge that samples rstIn low.
    task automatic do_reset(output int b);
        int s;
        s = edge_n;
        rst = 1'b1;
        expect_at(s + 1, "reset_state", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        wait_until(s + 3);
        check_now("reset_hold", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        rst = 1'b0;
        b = edge_n + 1;
    endtask

    // RELEASE entered at edge r: bits fall every 8 edges, RUN 8 edges after the last.
    task automatic exp_release(input int r, input logic [1:0] rt, input logic [7:0] ls);
        expect_at(r,      "rel_entry", 3'd2, 1'b0, 4'hF, 1'b0, 1'b0, rt,   ls);
        expect_at(r + 7,  "rel_hold",  3'd2, 1'b0, 4'hF, 1'b0, 1'b0, rt,   ls);
        expect_at(r + 8,  "rel_bit0",  3'd2, 1'b0, 4'hE, 1'b0, 1'b0, rt,   ls);
        expect_at(r + 16, "rel_bit1",  3'd2, 1'b0, 4'hC, 1'b0, 1'b0, rt,   ls);
        expect_at(r + 24, "rel_bit2",  3'd2, 1'b0, 4'h8, 1'b0, 1'b0, rt,   ls);
        expect_at(r + 32, "rel_bit3",  3'd2, 1'b0, 4'h0, 1'b0, 1'b0, rt,   ls);
        expect_at(r + 39, "rel_last",  3'd2, 1'b0, 4'h0, 1'b0, 1'b0, rt,   ls);
        expect_at(r + 40, "run_entry", 3'd3, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, ls);
    endtask

    initial begin
        int b;
        int l;
        logic [7:0] old_loss;
        logic [7:0] new_loss;

        bus.lockedIn = 2'b11;
        @(negedge clk);

        // Nominal bring-up
        do_reset(b);
        expect_at(b + 15, "mmcm_hold",   3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(b + 16, "mmcm_fall",   3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(b + 19, "filter_wait", 3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        exp_release(b + 20, 2'd0, 8'd0);
        wait_until(b + 62);

        // Lock glitch during WAIT_LOCK restarts the filter
        do_reset(b);
        expect_at(b + 16, "glitch_wl", 3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        wait_until(b + 16);
        bus.lockedIn = 2'b01;
        expect_at(b + 18, "glitch_mid", 3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        wait_until(b + 18);
        bus.lockedIn = 2'b11;
        expect_at(b + 23, "glitch_filter", 3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        exp_release(b + 24, 2'd0, 8'd0);
        wait_until(b + 70);

        // Lock loss in RUN, repeated until the loss counter saturates
        for (int i = 0; i < 300; i++) begin
            l = edge_n;
            old_loss = (i >= 255) ? 8'd255 : 8'(i);
            new_loss = (i >= 254) ? 8'd255 : 8'(i + 1);
            bus.lockedIn = 2'b10;
            expect_at(l + 2,  "loss_before", 3'd3, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, old_loss);
            expect_at(l + 3,  "loss_hit",    3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, new_loss);
            expect_at(l + 18, "loss_mmcm",   3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, new_loss);
            expect_at(l + 19, "loss_wl",     3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, new_loss);
            exp_release(l + 23, 2'd0, new_loss);
            wait_until(l + 1);
            bus.lockedIn = 2'b11;
            wait_until(l + 66);
        end

        // Reset mid-RELEASE after bits 0 and 1 have released
        l = edge_n;
        bus.lockedIn = 2'b10;
        expect_at(l + 3,  "sat_loss",  3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 8'd255);
        expect_at(l + 31, "mid_bit0",  3'd2, 1'b0, 4'hE, 1'b0, 1'b0, 2'd0, 8'd255);
        expect_at(l + 39, "mid_bit1",  3'd2, 1'b0, 4'hC, 1'b0, 1'b0, 2'd0, 8'd255);
        wait_until(l + 1);
        bus.lockedIn = 2'b11;
        wait_until(l + 42);
        rst = 1'b1;
        expect_at(l + 43, "mid_reset", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        wait_until(l + 43);
        rst = 1'b0;
        b = l + 44;
        expect_at(b + 15, "mid_mmcm_hold", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(b + 16, "mid_mmcm_fall", 3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        exp_release(b + 20, 2'd0, 8'd0);
        wait_until(b + 62);

        // Timeout retry: lock arrives after the first timeout
        bus.lockedIn = 2'b10;
        do_reset(b);
        expect_at(b + 16, "tr_wl",       3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(b + 79, "tr_pre_tmo",  3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(b + 80, "tr_timeout",  3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd1, 8'd0);
        wait_until(b + 82);
        bus.lockedIn = 2'b11;
        expect_at(b + 95, "tr_pulse_end", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd1, 8'd0);
        expect_at(b + 96, "tr_wl2",       3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd1, 8'd0);
        exp_release(b + 100, 2'd1, 8'd0);
        wait_until(b + 145);

        // Fault: lock never arrives
        bus.lockedIn = 2'b00;
        do_reset(b);
        expect_at(b + 16,  "f_wl1",      3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(b + 80,  "f_tmo1",     3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd1, 8'd0);
        expect_at(b + 96,  "f_wl2",      3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd1, 8'd0);
        expect_at(b + 160, "f_tmo2",     3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd2, 8'd0);
        expect_at(b + 240, "f_tmo3",     3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd3, 8'd0);
        expect_at(b + 255, "f_pulse4",   3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd3, 8'd0);
        expect_at(b + 256, "f_wl4",      3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd3, 8'd0);
        expect_at(b + 319, "f_pre",      3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd3, 8'd0);
        expect_at(b + 320, "f_fault",    3'd4, 1'b0, 4'hF, 1'b0, 1'b1, 2'd3, 8'd0);
        wait_until(b + 330);
        check_now("f_expired_wait", 3'd4, 1'b0, 4'hF, 1'b0, 1'b1, 2'd3, 8'd0);
        bus.lockedIn = 2'b11;
        expect_at(b + 400, "f_sticky",   3'd4, 1'b0, 4'hF, 1'b0, 1'b1, 2'd3, 8'd0);
        wait_until(b + 401);
        do_reset(b);
        wait_until(b + 2);

        finish_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
